store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 166 ++++++++++++++++
 tb/tb_store_buffer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : store_buffer
//  Purpose  : Post-commit store buffer between the MEM stage and data memory.
//             Stores are queued in a circular FIFO and drained one per cycle
//             while memory is idle. Loads are checked against pending entries
//             by word address so that they never observe stale memory.
//  Ports    : CLK, RESET (sync, active-high)
//             MEM_WRITE / MEM_READ / MEM_ADDRESS / MEM_WRITE_DATA / MEM_FUNC3
//                - MEM-stage store/load request
//             DM_BUSYWAIT          - data memory busy, drain write held off
//             DM_WRITE / DM_ADDRESS / DM_WRITEDATA / DM_FUNC3 - drain port
//             LOAD_HIT / LOAD_FWD_DATA - store-to-load forwarding result
//             STALL                - freeze pipeline this cycle
//             EMPTY                - no pending stores
//  Config   : STORE_BUF_FWD_EN - when defined, a load whose youngest match is
//             a word store is served from the buffer; otherwise any matching
//             load stalls until the matching entries have drained.
//  Revision : 1.0 - initial release
// ============================================================================
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        MEM_WRITE,
   input  logic        MEM_READ,
   input  logic [31:0] MEM_ADDRESS,
   input  logic [31:0] MEM_WRITE_DATA,
   input  logic [2:0]  MEM_FUNC3,
   input  logic        DM_BUSYWAIT,
   output logic        DM_WRITE,
   output logic [31:0] DM_ADDRESS,
   output logic [31:0] DM_WRITEDATA,
   output logic [2:0]  DM_FUNC3,
   output logic        LOAD_HIT,
   output logic [31:0] LOAD_FWD_DATA,
   output logic        STALL,
   output logic        EMPTY
);

   localparam int            PW         = $clog2(DEPTH);
   localparam logic [PW:0]   FULL_COUNT = (PW+1)'(DEPTH);
   localparam logic [2:0]    F3_WORD    = 3'b010;

   logic [31:0]    ent_addr  [DEPTH];
   logic [31:0]    ent_data  [DEPTH];
   logic [2:0]     ent_func3 [DEPTH];
   logic [DEPTH-1:0] ent_valid;
   logic [PW-1:0]  head;
   logic [PW-1:0]  tail;
   logic [PW:0]    count;

   logic full;
   logic push;
   logic pop;
   logic load_req;
   logic match;
   logic load_stall;
   logic [PW-1:0] slot;

   assign full = (count == FULL_COUNT);
   // A pop in the same cycle never frees room for a store while full.
   assign push = MEM_WRITE && !full;
   assign pop  = DM_WRITE && !DM_BUSYWAIT;
   // A simultaneous store request wins; the load side is ignored.
   assign load_req = MEM_READ && !MEM_WRITE;

   // Control state
   always_ff @(posedge CLK) begin
      if (RESET) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         ent_valid <= '0;
      end else begin
         if (push) begin
            ent_valid[tail] <= 1'b1;
            tail            <= tail + PW'(1);
         end
         if (pop) begin
            ent_valid[head] <= 1'b0;
            head            <= head + PW'(1);
         end
         if (push && !pop)
            count <= count + (PW+1)'(1);
         else if (pop && !push)
            count <= count - (PW+1)'(1);
      end
   end

   // Payload storage needs no reset: validity is tracked separately.
   always_ff @(posedge CLK) begin
      if (!RESET && push) begin
         ent_addr[tail]  <= MEM_ADDRESS;
         ent_data[tail]  <= MEM_WRITE_DATA;
         ent_func3[tail] <= MEM_FUNC3;
      end
   end

   // Drain port always presents the oldest entry.
   assign DM_WRITE     = (count != '0);
   assign DM_ADDRESS   = DM_WRITE ? ent_addr[head]  : 32'h0;
   assign DM_WRITEDATA = DM_WRITE ? ent_data[head]  : 32'h0;
   assign DM_FUNC3     = DM_WRITE ? ent_func3[head] : 3'b000;
   assign EMPTY        = (count == '0);

`ifdef STORE_BUF_FWD_EN
   logic [PW-1:0] match_idx;
`endif

   // Walk from oldest to youngest so the last hit is the youngest match.
   always_comb begin
      match = 1'b0;
      slot  = head;
`ifdef STORE_BUF_FWD_EN
      match_idx = head;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         slot = head + PW'(k);
         if (ent_valid[slot] && (ent_addr[slot][31:2] == MEM_ADDRESS[31:2])) begin
            match = 1'b1;
`ifdef STORE_BUF_FWD_EN
            match_idx = slot;
`endif
         end
      end
   end

`ifdef STORE_BUF_FWD_EN
   logic [31:0] fwd_word;
   logic        fwd_is_word;
   logic [7:0]  fwd_byte;
   logic [15:0] fwd_half;
   logic [31:0] fwd_ext;

   assign fwd_word    = ent_data[match_idx];
   assign fwd_is_word = (ent_func3[match_idx] == F3_WORD);
   assign fwd_byte    = 8'(fwd_word >> {MEM_ADDRESS[1:0], 3'b000});
   assign fwd_half    = 16'(fwd_word >> {MEM_ADDRESS[1], 4'b0000});

   always_comb begin
      fwd_ext = fwd_word;
      case (MEM_FUNC3)
         3'b000:  fwd_ext = {{24{fwd_byte[7]}}, fwd_byte};
         3'b001:  fwd_ext = {{16{fwd_half[15]}}, fwd_half};
         3'b100:  fwd_ext = {24'h0, fwd_byte};
         3'b101:  fwd_ext = {16'h0, fwd_half};
         default: fwd_ext = fwd_word;
      endcase
   end

   // A partial-width store cannot supply a full load value; wait for it.
   assign load_stall    = load_req && match && !fwd_is_word;
   assign LOAD_HIT      = load_req && match && fwd_is_word;
   assign LOAD_FWD_DATA = LOAD_HIT ? fwd_ext : 32'h0;
`else
   assign load_stall    = load_req && match;
   assign LOAD_HIT      = 1'b0;
   assign LOAD_FWD_DATA = 32'h0;
`endif

   assign STALL = (MEM_WRITE && full) || load_stall;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_buffer
//  Purpose  : Directed self-checking bench for store_buffer. Every accepted
//             store is pushed to an expected-drain queue and popped when the
//             drain port writes to memory. Load results are given per step.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

   localparam int DEPTH = 4;
`ifdef STORE_BUF_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RESET;
   logic        MEM_WRITE;
   logic        MEM_READ;
   logic [31:0] MEM_ADDRESS;
   logic [31:0] MEM_WRITE_DATA;
   logic [2:0]  MEM_FUNC3;
   logic        DM_BUSYWAIT;
   logic        DM_WRITE;
   logic [31:0] DM_ADDRESS;
   logic [31:0] DM_WRITEDATA;
   logic [2:0]  DM_FUNC3;
   logic        LOAD_HIT;
   logic [31:0] LOAD_FWD_DATA;
   logic        STALL;
   logic        EMPTY;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [2:0]  f;
   } ent_t;

   ent_t exp_q[$];
   int   vectors = 0;
   int   fails   = 0;
   int   step    = 0;

   store_buffer #(.DEPTH(DEPTH)) dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .MEM_WRITE     (MEM_WRITE),
      .MEM_READ      (MEM_READ),
      .MEM_ADDRESS   (MEM_ADDRESS),
      .MEM_WRITE_DATA(MEM_WRITE_DATA),
      .MEM_FUNC3     (MEM_FUNC3),
      .DM_BUSYWAIT   (DM_BUSYWAIT),
      .DM_WRITE      (DM_WRITE),
      .DM_ADDRESS    (DM_ADDRESS),
      .DM_WRITEDATA  (DM_WRITEDATA),
      .DM_FUNC3      (DM_FUNC3),
      .LOAD_HIT      (LOAD_HIT),
      .LOAD_FWD_DATA (LOAD_FWD_DATA),
      .STALL         (STALL),
      .EMPTY         (EMPTY)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL step%0d %s: observed %h expected %h", step, tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check outputs mid-cycle, update the model.
   task automatic cycle(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f,
                        input logic busy, input logic rst,
                        input logic e_stall, input logic e_hit,
                        input logic [31:0] e_data);
      ent_t e;
      bit   accept;
      step++;
      RESET          = rst;
      MEM_WRITE      = w;
      MEM_READ       = r;
      MEM_ADDRESS    = a;
      MEM_WRITE_DATA = d;
      MEM_FUNC3      = f;
      DM_BUSYWAIT    = busy;
      #1;
      chk("stall",    {31'h0, STALL},    {31'h0, e_stall});
      chk("load_hit", {31'h0, LOAD_HIT}, {31'h0, e_hit});
      chk("fwd_data", LOAD_FWD_DATA,     e_data);
      chk("empty",    {31'h0, EMPTY},    {31'h0, exp_q.size() == 0});
      chk("dm_write", {31'h0, DM_WRITE}, {31'h0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
         chk("dm_addr",  DM_ADDRESS,          exp_q[0].a);
         chk("dm_data",  DM_WRITEDATA,        exp_q[0].d);
         chk("dm_func3", {29'h0, DM_FUNC3},   {29'h0, exp_q[0].f});
      end else begin
         chk("dm_addr_idle", DM_ADDRESS,   32'h0);
         chk("dm_data_idle", DM_WRITEDATA, 32'h0);
      end
      if (rst) begin
         exp_q.delete();
      end else begin
         accept = w && (exp_q.size() < DEPTH);
         if (exp_q.size() != 0 && !busy)
            void'(exp_q.pop_front());
         if (accept) begin
            e.a = a; e.d = d; e.f = f;
            exp_q.push_back(e);
         end
      end
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                     input logic busy, input logic e_stall);
      cycle(1'b1, 1'b0, a, d, f, busy, 1'b0, e_stall, 1'b0, 32'h0);
   endtask

   task automatic ld(input logic [31:0] a, input logic [2:0] f, input logic busy,
                     input logic e_stall, input logic e_hit, input logic [31:0] e_data);
      cycle(1'b0, 1'b1, a, 32'h0, f, busy, 1'b0, e_stall, e_hit, e_data);
   endtask

   task automatic idle(input logic busy);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, busy, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   // Expected result of a load that hits a pending word store.
   function automatic logic [31:0] fw(input logic [31:0] v);
      return FWD ? v : 32'h0;
   endfunction

   initial begin
      RESET = 1'b1; MEM_WRITE = 1'b0; MEM_READ = 1'b0; MEM_ADDRESS = '0;
      MEM_WRITE_DATA = '0; MEM_FUNC3 = '0; DM_BUSYWAIT = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);

      // Reset cycle with a store request present: the store is ignored.
      cycle(1'b1, 1'b0, 32'h0000_0010, 32'h1111_1111, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      idle(1'b0);

      // SW then LB from the top byte of the same word.
      st(32'h100, 32'hDEAD_BEEF, 3'b010, 1'b0, 1'b0);
      ld(32'h103, 3'b000, 1'b0, !FWD, FWD, fw(32'hFFFF_FFDE));
      ld(32'h103, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);

      // Extraction variants against one held word store.
      st(32'h180, 32'h8001_7F80, 3'b010, 1'b1, 1'b0);
      ld(32'h180, 3'b100, 1'b1, !FWD, FWD, fw(32'h0000_0080));
      ld(32'h181, 3'b000, 1'b1, !FWD, FWD, fw(32'h0000_007F));
      ld(32'h182, 3'b001, 1'b1, !FWD, FWD, fw(32'hFFFF_8001));
      ld(32'h182, 3'b101, 1'b1, !FWD, FWD, fw(32'h0000_8001));
      ld(32'h180, 3'b010, 1'b1, !FWD, FWD, fw(32'h8001_7F80));
      ld(32'h184, 3'b010, 1'b1, 1'b0, 1'b0, 32'h0);
      // Store and load together: store wins, no hit.
      cycle(1'b1, 1'b1, 32'h180, 32'h0000_1234, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      idle(1'b0);
      idle(1'b0);

      // Byte store then word load: stall until the entry drains.
      st(32'h200, 32'h0000_007F, 3'b000, 1'b1, 1'b0);
      ld(32'h200, 3'b010, 1'b1, 1'b1, 1'b0, 32'h0);
      ld(32'h200, 3'b010, 1'b1, 1'b1, 1'b0, 32'h0);
      ld(32'h200, 3'b010, 1'b0, 1'b1, 1'b0, 32'h0);
      ld(32'h200, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0);

      // Youngest match wins; a younger byte store forces a stall.
      st(32'h300, 32'h0000_0001, 3'b010, 1'b1, 1'b0);
      st(32'h300, 32'h0000_0002, 3'b010, 1'b1, 1'b0);
      ld(32'h300, 3'b010, 1'b1, !FWD, FWD, fw(32'h0000_0002));
      st(32'h301, 32'h0000_0055, 3'b000, 1'b1, 1'b0);
      ld(32'h300, 3'b010, 1'b1, 1'b1, 1'b0, 32'h0);
      repeat (3) idle(1'b0);
      ld(32'h300, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0);

      // Fill while memory is busy; the extra store stalls.
      for (int i = 0; i < DEPTH; i++)
         st(32'h400 + 32'(4 * i), 32'hA0 + 32'(i), 3'b010, 1'b1, 1'b0);
      st(32'h410, 32'hA4, 3'b010, 1'b1, 1'b1);
      // Full with a pop in the same cycle: still no enqueue.
      st(32'h410, 32'hA4, 3'b010, 1'b0, 1'b1);
      // Not full: enqueue and pop together.
      st(32'h414, 32'hA5, 3'b010, 1'b0, 1'b0);
      repeat (4) idle(1'b0);

      // Reset with three entries pending discards them.
      st(32'h500, 32'h0000_0501, 3'b010, 1'b1, 1'b0);
      st(32'h504, 32'h0000_0502, 3'b001, 1'b1, 1'b0);
      st(32'h508, 32'h0000_0503, 3'b000, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      idle(1'b0);
      idle(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
`default_nettype wire
